// File: rtl/cricket_pkg.sv
// Shared constants and state type for the innings tracking blocks.
// Default innings shape is a 20-over, 10-wicket innings of 6-ball overs.
package cricket_pkg;

    localparam int DEF_BALLS_PER_OVER = 6;
    localparam int DEF_MAX_OVERS      = 20;
    localparam int DEF_MAX_WICKETS    = 10;

    typedef enum logic {
        ACTIVE = 1'b0,
        DONE   = 1'b1
    } innings_state_t;

endpackage : cricket_pkg

// File: rtl/innings_progress_tracker_if.sv
// Delivery-event inputs and innings progress outputs between the ball-event
// decoder (master) and the innings tracker (slave).
interface innings_progress_tracker_if #(
    parameter int BALL_W  = 3,
    parameter int OVER_W  = 5,
    parameter int WKT_W   = 4,
    parameter int EXTRA_W = 8
);
    logic               new_innings;
    logic               ball_valid;
    logic               ball_legal;
    logic               wicket;
    logic [BALL_W-1:0]  balls;
    logic [OVER_W-1:0]  overs;
    logic [EXTRA_W-1:0] extras;
    logic [WKT_W-1:0]   wickets;
    logic               over_complete;
    logic               innings_done;

    modport master (
        output new_innings, ball_valid, ball_legal, wicket,
        input  balls, overs, extras, wickets, over_complete, innings_done
    );

    modport slave (
        input  new_innings, ball_valid, ball_legal, wicket,
        output balls, overs, extras, wickets, over_complete, innings_done
    );

endinterface : innings_progress_tracker_if

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with a combinational wrap flag raised when an
// increment is applied at N-1.
module mod_n_counter #(
    parameter int N = 6,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_reg;

    assign wrap  = inc && (count_reg == LAST);
    assign count = count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= wrap ? '0 : count_reg + W'(1);
        end
    end

endmodule : mod_n_counter

// File: rtl/innings_progress_tracker.sv
// Tracks balls, overs, extras and wickets for one innings and flags the
// innings complete on the over or wicket limit.
module innings_progress_tracker
    import cricket_pkg::*;
#(
    parameter int BALLS_PER_OVER = DEF_BALLS_PER_OVER,
    parameter int MAX_OVERS      = DEF_MAX_OVERS,
    parameter int MAX_WICKETS    = DEF_MAX_WICKETS,
    parameter int EXTRA_W        = 8,
    parameter int BALL_W         = $clog2(BALLS_PER_OVER),
    parameter int OVER_W         = $clog2(MAX_OVERS + 1),
    parameter int WKT_W          = $clog2(MAX_WICKETS + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    innings_progress_tracker_if.slave   bus
);

    localparam logic [OVER_W-1:0] OVER_LIMIT = OVER_W'(MAX_OVERS);
    localparam logic [WKT_W-1:0]  WKT_LIMIT  = WKT_W'(MAX_WICKETS);

    innings_state_t     state_reg, state_next;
    logic [OVER_W-1:0]  overs_reg, overs_next;
    logic [EXTRA_W-1:0] extras_reg, extras_next;
    logic [WKT_W-1:0]   wickets_reg, wickets_next;
    logic               over_complete_reg;
    logic [BALL_W-1:0]  balls_cnt;
    logic               ball_wrap;
    logic               delivery;
    logic               legal_ball;

    // A new innings drops any delivery presented on the same cycle.
    assign delivery   = (state_reg == ACTIVE) && bus.ball_valid && !bus.new_innings;
    assign legal_ball = delivery && bus.ball_legal;

    mod_n_counter #(
        .N (BALLS_PER_OVER),
        .W (BALL_W)
    ) u_balls (
        .clk   (clk),
        .reset (reset),
        .clear (bus.new_innings),
        .inc   (legal_ball),
        .count (balls_cnt),
        .wrap  (ball_wrap)
    );

    always_comb begin
        overs_next   = overs_reg;
        extras_next  = extras_reg;
        wickets_next = wickets_reg;
        if (ball_wrap) begin
            overs_next = overs_reg + OVER_W'(1);
        end
        if (delivery && !bus.ball_legal && (extras_reg != '1)) begin
            extras_next = extras_reg + EXTRA_W'(1);
        end
        // Wickets count on illegal deliveries too (e.g. run-out off a no-ball).
        if (delivery && bus.wicket) begin
            wickets_next = wickets_reg + WKT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.new_innings) begin
            overs_reg         <= '0;
            extras_reg        <= '0;
            wickets_reg       <= '0;
            over_complete_reg <= 1'b0;
        end else begin
            overs_reg         <= overs_next;
            extras_reg        <= extras_next;
            wickets_reg       <= wickets_next;
            over_complete_reg <= ball_wrap;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ACTIVE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        if (bus.new_innings) begin
            state_next = ACTIVE;
        end else if (state_reg == ACTIVE && delivery &&
                     (overs_next == OVER_LIMIT || wickets_next == WKT_LIMIT)) begin
            state_next = DONE;
        end
    end

    // FSM outputs
    always_comb begin
        bus.innings_done = (state_reg == DONE);
    end

    assign bus.balls         = balls_cnt;
    assign bus.overs         = overs_reg;
    assign bus.extras        = extras_reg;
    assign bus.wickets       = wickets_reg;
    assign bus.over_complete = over_complete_reg;

endmodule : innings_progress_tracker

// File: doc/innings_progress_tracker.md
Name: innings_progress_tracker

Overview:
Parametrised successor to the single-width over counter. Counts legal deliveries within an over, completed overs, extras (wides/no-balls) and wickets for one innings. Raises an innings-complete condition on the over limit or the wicket limit. Sits between the ball-event decoder and the scoreboard/display logic, and drives the over-change pulse to bowler-rotation logic.

Parameters:
BALLS_PER_OVER, 6, legal deliveries per over; must be at least 2.
MAX_OVERS, 20, over limit for the innings; must be at least 1.
MAX_WICKETS, 10, wickets that end the innings.
EXTRA_W, 8, width of the extras counter.
BALL_W, $clog2(BALLS_PER_OVER), derived width of the balls field; do not override.
OVER_W, $clog2(MAX_OVERS+1), derived width of the overs field (5 at default).
WKT_W, $clog2(MAX_WICKETS+1), derived width of the wickets field.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high; clears all state.
new_innings  in  1  single-cycle pulse; clears counters and starts a fresh innings.
ball_valid  in  1  one delivery event this cycle.
ball_legal  in  1  qualifies ball_valid: 1 = legal delivery, 0 = wide/no-ball.
wicket  in  1  qualifies ball_valid: a wicket fell on this delivery.
balls  out  BALL_W  legal balls bowled in the current over, 0..BALLS_PER_OVER-1.
overs  out  OVER_W  completed overs, 0..MAX_OVERS.
extras  out  EXTRA_W  count of illegal deliveries; saturates at all-ones.
wickets  out  WKT_W  wickets fallen, 0..MAX_WICKETS.
over_complete  out  1  one-cycle pulse on the cycle the overs field increments.
innings_done  out  1  level; high in DONE state.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: balls=0, overs=0, extras=0, wickets=0, over_complete=0, innings_done=0, state=ACTIVE.
- All outputs are registered. An event sampled at edge N is visible after edge N; latency is one cycle.
- FSM has two states, ACTIVE and DONE.
  - ACTIVE -> DONE when the post-update overs==MAX_OVERS or the post-update wickets==MAX_WICKETS.
  - DONE -> ACTIVE only on new_innings.
  - DONE is never entered from reset.
- In ACTIVE, with ball_valid=1:
  - ball_legal=1 and balls<BALLS_PER_OVER-1: balls increments.
  - ball_legal=1 and balls==BALLS_PER_OVER-1: balls wraps to 0, overs increments, over_complete pulses for exactly one cycle.
  - ball_legal=0: extras increments (saturating); balls and overs are unchanged.
  - wicket=1: wickets increments regardless of ball_legal, so a run-out off a no-ball counts.
- Simultaneous events:
  - Last legal ball of an over with a wicket: both overs and wickets update in the same cycle, and over_complete pulses.
  - Both limits reached on the same edge: DONE is entered once.
- In DONE: ball_valid is ignored, all counters hold, over_complete stays 0.
- ball_valid=0: ball_legal and wicket are don't-care and no counter changes.
- new_innings:
  - Clears balls, overs, extras and wickets, sets state=ACTIVE, and drives over_complete=0.
  - Takes priority over ball_valid in the same cycle; that delivery is dropped.
- reset has priority over everything. Reset mid-over clears all counters on that edge.
- Overs never exceed MAX_OVERS. Wickets never exceed MAX_WICKETS.

Decomposition:
- Shared package cricket_pkg:
  - default constants DEF_BALLS_PER_OVER=6, DEF_MAX_OVERS=20, DEF_MAX_WICKETS=10;
  - typedef innings_state_t {ACTIVE, DONE}.
- One sub-module, mod_n_counter (parameter N, width clog2(N)):
  - inputs: clk, reset, clear, inc;
  - outputs: count, wrap, where wrap is a combinational flag for inc at N-1;
  - instantiated for balls.
- The top level holds the overs, extras and wickets counters, the FSM and the over_complete register.

Test Plan:
1. Defaults, reset, then 6 legal balls -> balls goes 1..5 then 0, overs=1, over_complete high for exactly one cycle, extras=0.
2. Legal, wide, no-ball, then 5 legal balls -> overs=1, balls=0, extras=2. over_complete pulses only after the sixth legal ball.
3. MAX_OVERS=2, 12 legal balls -> overs=2, innings_done=1 from the cycle after ball 12. A 13th ball leaves balls=0 and overs=2; new_innings then clears everything and innings_done=0.
4. Ten wickets on legal balls (overs=1, balls=4 at the tenth) -> wickets=10, innings_done=1. A later ball_valid changes nothing.
5. Wicket on the sixth legal ball with wickets=9 -> overs=1, wickets=10, over_complete pulses, innings_done=1, all on the same edge.
6. Reset asserted after 3 legal balls and 1 wide -> all outputs 0 on the next cycle. Also: new_innings and ball_valid in the same cycle -> counters 0 and the ball is not counted. Also: 300 wides with EXTRA_W=8 -> extras saturates at 255.
